// File: rtl/axi4_burst_mem_responder.sv
// axi4_burst_mem_responder: AXI4 slave backed by a word-addressed memory,
// servicing one burst at a time with alternating write/read priority.
module axi4_burst_mem_responder #(
   parameter int C_S_AXI_ID_WIDTH   = 1,
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_MEM_WORDS        = 1024
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_AWID,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic [7:0]                    S_AXI_AWLEN,
   input  logic [2:0]                    S_AXI_AWSIZE,
   input  logic [1:0]                    S_AXI_AWBURST,
   input  logic                          S_AXI_AWVALID,
   output logic                          S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                          S_AXI_WLAST,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_BID,
   output logic [1:0]                    S_AXI_BRESP,
   output logic                          S_AXI_BVALID,
   input  logic                          S_AXI_BREADY,
   input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic [7:0]                    S_AXI_ARLEN,
   input  logic [2:0]                    S_AXI_ARSIZE,
   input  logic [1:0]                    S_AXI_ARBURST,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
   output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RLAST,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY
);
   localparam int AW = C_S_AXI_ADDR_WIDTH;
   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int IW = $clog2(C_MEM_WORDS);
   typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;
   state_t                     state_q;
   logic                       rst_q, pri_wr_q, err_q;
   logic [C_S_AXI_ID_WIDTH-1:0] id_q;
   logic [AW-1:0]              addr_q, addr_d;
   logic [7:0]                 len_q;
   logic [1:0]                 burst_q;
   logic [8:0]                 cnt_q;
   logic                       oor, last, bad, aw_hs, ar_hs, w_hs, r_hs;
   logic [IW-1:0]              idx;
   logic [DW-1:0]              mem [C_MEM_WORDS];
   always_comb begin
      oor    = {2'b00, addr_q[AW-1:2]} >= AW'(C_MEM_WORDS);
      idx    = addr_q[IW+1:2];
      last   = cnt_q == {1'b0, len_q};
      bad    = err_q || oor;
      addr_d = burst_q == 2'b01 ? addr_q + AW'(4) : addr_q;
   end
   // Readies stay low for one cycle after reset so an abandoned burst is visibly dropped
   assign S_AXI_AWREADY = state_q == IDLE && !rst_q && (pri_wr_q || !S_AXI_ARVALID);
   assign S_AXI_ARREADY = state_q == IDLE && !rst_q && (!pri_wr_q || !S_AXI_AWVALID);
   assign S_AXI_WREADY  = state_q == WDATA;
   assign S_AXI_BVALID  = state_q == WRESP;
   assign S_AXI_BID     = id_q;
   assign S_AXI_BRESP   = S_AXI_BVALID && err_q ? 2'b10 : 2'b00;
   assign S_AXI_RVALID  = state_q == RDATA;
   assign S_AXI_RID     = id_q;
   assign S_AXI_RDATA   = S_AXI_RVALID && !bad ? mem[idx] : '0;
   assign S_AXI_RRESP   = S_AXI_RVALID && bad ? 2'b10 : 2'b00;
   assign S_AXI_RLAST   = S_AXI_RVALID && last;
   assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
   assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
   assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
   assign r_hs  = S_AXI_RVALID && S_AXI_RREADY;
   always_ff @(posedge ACLK)
      if (!ARESET && w_hs && !bad)
         for (int b = 0; b < DW/8; b++)
            if (S_AXI_WSTRB[b]) mem[idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q  <= IDLE;
         rst_q    <= 1'b1;
         pri_wr_q <= 1'b1;
         err_q    <= 1'b0;
         id_q     <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         burst_q  <= '0;
         cnt_q    <= '0;
      end else begin
         rst_q <= 1'b0;
         case (state_q)
            IDLE:
               if (aw_hs) begin
                  id_q     <= S_AXI_AWID;
                  addr_q   <= S_AXI_AWADDR;
                  len_q    <= S_AXI_AWLEN;
                  burst_q  <= S_AXI_AWBURST;
                  err_q    <= S_AXI_AWSIZE != 3'd2 || S_AXI_AWBURST[1];
                  cnt_q    <= '0;
                  pri_wr_q <= 1'b0;
                  state_q  <= WDATA;
               end else if (ar_hs) begin
                  id_q     <= S_AXI_ARID;
                  addr_q   <= S_AXI_ARADDR;
                  len_q    <= S_AXI_ARLEN;
                  burst_q  <= S_AXI_ARBURST;
                  err_q    <= S_AXI_ARSIZE != 3'd2 || S_AXI_ARBURST[1];
                  cnt_q    <= '0;
                  pri_wr_q <= 1'b1;
                  state_q  <= RDATA;
               end
            WDATA:
               if (w_hs) begin
                  err_q   <= err_q || oor || (S_AXI_WLAST != last);
                  addr_q  <= addr_d;
                  cnt_q   <= cnt_q + 9'd1;
                  state_q <= last ? WRESP : WDATA;
               end
            WRESP:
               if (S_AXI_BREADY) state_q <= IDLE;
            default:
               if (r_hs) begin
                  addr_q  <= addr_d;
                  cnt_q   <= cnt_q + 9'd1;
                  state_q <= last ? IDLE : RDATA;
               end
         endcase
      end
   end
endmodule

// File: doc/axi4_burst_mem_responder.md
Name: axi4_burst_mem_responder

Overview:
- Synthesizable AXI4-Full slave that answers the DMA's M00/M01 master ports with a word-addressed memory. It is the responder end of the burst interface the DMA drives.
- Used in place of the slave VIP in hardware and system-level benches. It stores write bursts and returns them on read bursts, so DMA copy results can be checked on-chip.
- Services one transaction at a time. Write and read channels are arbitrated fairly.

Parameters:
- C_S_AXI_ID_WIDTH, 1, width of AWID/BID/ARID/RID.
- C_S_AXI_ADDR_WIDTH, 32, address width.
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_MEM_WORDS, 1024, memory depth in 32-bit words. Byte range is 0 to 4*C_MEM_WORDS-1.

Ports:
- ACLK in 1: clock; all logic on the rising edge.
- ARESET in 1: synchronous, active-high reset.
- S_AXI_AWID in ID; S_AXI_AWADDR in ADDR; S_AXI_AWLEN in 8; S_AXI_AWSIZE in 3; S_AXI_AWBURST in 2; S_AXI_AWVALID in 1; S_AXI_AWREADY out 1: write address channel.
- S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WLAST in 1; S_AXI_WVALID in 1; S_AXI_WREADY out 1: write data channel.
- S_AXI_BID out ID; S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1: write response channel.
- S_AXI_ARID in ID; S_AXI_ARADDR in ADDR; S_AXI_ARLEN in 8; S_AXI_ARSIZE in 3; S_AXI_ARBURST in 2; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1: read address channel.
- S_AXI_RID out ID; S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RLAST out 1; S_AXI_RVALID out 1; S_AXI_RREADY in 1: read data channel.

Behaviour:
- FSM states: IDLE, WDATA, WRESP, RDATA.
- Reset:
  - State goes to IDLE and all VALID/READY outputs go to 0.
  - BID, BRESP, RID, RDATA, RRESP, RLAST go to 0.
  - pri_wr flag goes to 1; err flag goes to 0.
  - Memory contents are not cleared.
  - Reset mid-burst abandons the transaction immediately; beats already written stay written.
- IDLE:
  - AWREADY = (state==IDLE) && (pri_wr || !ARVALID).
  - ARREADY = (state==IDLE) && (!pri_wr || !AWVALID).
  - Both are combinational from registered state. Only one handshake can occur per cycle.
  - AW handshake: latch ID, addr, len, burst, and err = (AWSIZE!=2 || AWBURST is WRAP or reserved). Set pri_wr=0 and go to WDATA.
  - AR handshake: latch ID, addr, len, burst and err likewise. Set pri_wr=1 and go to RDATA.
  - The flag toggle gives alternating priority when AW and AR are valid together.
- WDATA:
  - WREADY=1.
  - Each W handshake writes the bytes with WSTRB set to mem[addr[.. :2]], unless the word is out of range or err is set.
  - An out-of-range beat sets err.
  - Address advances by 4 for INCR and stays fixed for FIXED.
  - Beat count is checked against latched len. A WLAST/count mismatch sets err.
  - Termination is on count reaching len+1; WLAST is not used to terminate.
  - After the final beat go to WRESP, so WREADY drops the next cycle.
- WRESP:
  - BVALID=1, BID = latched ID, BRESP = err ? 2'b10 (SLVERR) : 2'b00.
  - BVALID holds until BREADY; on the handshake go to IDLE.
- RDATA:
  - First beat RVALID=1 one cycle after the AR handshake.
  - RDATA is read combinationally from the memory at the registered beat address.
  - An out-of-range beat or err returns RDATA=0 with RRESP=SLVERR for that beat; otherwise RRESP=OKAY.
  - RLAST=1 on beat len. RID = latched ID.
  - Each RVALID && RREADY advances address and count, so one beat per cycle under continuous RREADY.
  - Outputs are held stable while RREADY=0.
  - After the last handshake go to IDLE.
- Boundaries:
  - An INCR burst crossing the end of memory errors only the beats past the end.
  - len=0 is a single beat: one W beat then B, or one R beat with RLAST=1.
  - len=255 gives 256 beats; the counter is 9 bits wide, no wrap.
  - Address arithmetic is modulo 2^ADDR_WIDTH.
- Throughput:
  - Write: B handshake 1 cycle after the last W beat at the earliest.
  - Read: no bubbles between beats.
  - Back-to-back transactions need 1 IDLE cycle.

Test Plan:
- Write INCR len=7 at 0x0 with data 1..8 and WSTRB=F; read INCR len=7 at 0x0 -> BRESP=OKAY; RDATA 1..8; RLAST only on beat 8; RID equals ARID.
- Write 0xAABBCCDD then write 0x11223344 with WSTRB=4'b0101 to 0x10; read 0x10 -> 0xAA22CC44.
- With C_MEM_WORDS=1024, write INCR len=3 at 0xFF8 -> BRESP=SLVERR; words 0x3FE and 0x3FF are written. Read the same burst -> beats 0 and 1 OKAY with data, beats 2 and 3 SLVERR with data 0.
- AWVALID and ARVALID held together for 4 transactions -> grants alternate W,R,W,R starting with write. No handshake overlap.
- Read len=3 with RREADY toggling 1,0,0,1,1,0,1 -> RDATA and RLAST stable during stalls; 4 beats in order.
- Assert ARESET for 1 cycle mid-write at beat 3 of len=7 -> all VALID/READY outputs are 0 the next cycle. A new read of the first 3 words returns the written data.
